// File: rtl/io_map_pkg.sv
// io_map_pkg: shared constants for the output-port write path.
//   - word indices (addr[7:2]) of the three output-port registers
//   - FSM state encoding used by io_write_arb
//   - is_io_port(): decodes a word index against the port map
package io_map_pkg;

  localparam logic [5:0] IO_PORT0_IDX = 6'h20;
  localparam logic [5:0] IO_PORT1_IDX = 6'h21;
  localparam logic [5:0] IO_PORT2_IDX = 6'h22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } io_state_t;

  function automatic logic is_io_port(input logic [5:0] word_idx);
    return (word_idx == IO_PORT0_IDX) ||
           (word_idx == IO_PORT1_IDX) ||
           (word_idx == IO_PORT2_IDX);
  endfunction

endpackage

// File: rtl/io_rr_pick.sv
// io_rr_pick: 2-way round-robin pick.
//   req0, req1  : pending requests
//   last_grant  : index of the requester granted most recently
//   grant       : index to grant (only meaningful when req0|req1)
// A single request always wins; on a tie the requester not granted last wins.
module io_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
  end

endmodule

// File: rtl/io_write_arb.sv
// io_write_arb: arbitrates two write requesters onto the output-port register
// bank. Each accepted write takes IDLE -> WRITE -> GAP, so at most one write
// every 3 cycles. Writes to addresses outside the port map are acknowledged
// but not issued, and counted in drop_cnt.
//   io_clk, resetn          : clock, asynchronous active-low reset
//   req0/addr0/data0        : requester 0 (CPU MEM stage)
//   req1/addr1/data1        : requester 1 (aux/debug master)
//   ack0, ack1              : one-cycle write-committed pulse (WRITE cycle)
//   io_addr, io_data, io_we : registered write port to the register bank
//   busy                    : FSM not in IDLE
//   drop_cnt                : saturating count of rejected writes
module io_write_arb
  import io_map_pkg::*;
(
  input  logic        io_clk,
  input  logic        resetn,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] io_addr,
  output logic [31:0] io_data,
  output logic        io_we,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  io_state_t   state;
  logic        last_grant;
  logic        pick;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;
  logic        sel_valid;

  io_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    sel_addr  = pick ? addr1 : addr0;
    sel_data  = pick ? data1 : data0;
    sel_valid = is_io_port(sel_addr[7:2]);
  end

  assign busy = (state != ST_IDLE);

  // io_we/ack are set on the edge into WRITE so they are high exactly during
  // the WRITE cycle; requests are only sampled in IDLE, so a request raised
  // in WRITE or GAP simply waits.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      io_addr    <= '0;
      io_data    <= '0;
      io_we      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            state      <= ST_WRITE;
            last_grant <= pick;
            io_addr    <= sel_addr;
            io_data    <= sel_data;
            io_we      <= sel_valid;
            ack0       <= ~pick;
            ack1       <= pick;
            if (!sel_valid && (drop_cnt != '1)) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
        end
        ST_WRITE: begin
          state <= ST_GAP;
          io_we <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          io_we <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/io_write_arb.md
IO_WRITE_ARB -- requirements
Module: io_write_arb

Interface
REQ-001 The module SHALL have these ports: io_clk  in  1  single clock, all state on rising edge.
REQ-002 The module SHALL have these ports: resetn  in  1  asynchronous active-low reset.
REQ-003 The module SHALL have these ports: req0  in  1  write request from requester 0 (CPU MEM stage).
REQ-004 The module SHALL have these ports: addr0, data0  in  32 each  requester-0 address and write data.
REQ-005 The module SHALL have these ports: req1  in  1  write request from requester 1 (aux/debug master).
REQ-006 The module SHALL have these ports: addr1, data1  in  32 each  requester-1 address and write data.
REQ-007 The module SHALL have these ports: ack0, ack1  out  1 each  one-cycle write-committed pulse per requester.
REQ-008 The module SHALL have these ports: io_addr, io_data  out  32 each  registered address and data to the output-port register bank.
REQ-009 The module SHALL have these ports: io_we  out  1  registered one-cycle write-enable to the output-port register bank.
REQ-010 The module SHALL have these ports: busy  out  1  high in any state other than IDLE.
REQ-011 The module SHALL have these ports: drop_cnt  out  8  saturating count of rejected writes.

Function
REQ-012 Requester protocol: reqN, addrN and dataN held stable from assertion until ackN; reqN low in the cycle after ackN.
REQ-013 FSM states SHALL be IDLE, WRITE, GAP; transitions: IDLE->WRITE when req0|req1; WRITE->GAP always; GAP->IDLE always.
REQ-014 In IDLE with exactly one request, that requester SHALL be granted; addr/data latched into io_addr/io_data at the same edge.
REQ-015 In IDLE with both requests, grant SHALL go to the requester not granted last (round-robin); last_grant reset value 1, so requester 0 wins the first tie.
REQ-016 last_grant SHALL update only on the IDLE->WRITE edge.
REQ-017 Valid address: latched addr[7:2] equals 6'h20, 6'h21 or 6'h22; other bits ignored.
REQ-018 In WRITE with a valid address, io_we SHALL be 1 for exactly that cycle; the granted ackN SHALL be 1 in the same cycle.
REQ-019 In WRITE with an invalid address, io_we SHALL stay 0, the granted ackN SHALL still pulse, and drop_cnt SHALL increment by 1, saturating at 8'hFF.
REQ-020 io_we and ack SHALL be 0 in IDLE and GAP; throughput SHALL be at most one write per 3 cycles; latency from req to io_we SHALL be 1 cycle from IDLE.
REQ-021 io_addr/io_data SHALL hold their last latched values outside WRITE.
REQ-022 A request arriving while not in IDLE SHALL wait and SHALL never be lost or acked early.
REQ-023 reqN dropped after grant (protocol violation) SHALL NOT abort the write; the write and ackN SHALL still complete.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-025 While resetn=0: state IDLE, io_addr=0, io_data=0, io_we=0, ack0=ack1=0, busy=0, drop_cnt=0, last_grant=1, independent of io_clk.
REQ-026 Reset asserted in WRITE or GAP SHALL discard the in-flight write with no further io_we or ack after reset release.
REQ-027 First grant is possible at the first rising edge after resetn rises.

Structure
REQ-028 Shared package io_map_pkg SHALL hold the port word-index constants (6'h20, 6'h21, 6'h22) and the FSM state encoding.
REQ-029 The 2-way round-robin pick (inputs req0, req1, last_grant; output grant index) SHALL be a sub-module named io_rr_pick.
REQ-030 Target size is 120-400 RTL lines; no other sub-modules.

Verification
REQ-031 Scenario: req0 only, addr0=32'h80, data0=32'hA5 -> next cycle io_we=1, io_addr=32'h80, io_data=32'hA5, ack0=1; drop_cnt=0.
REQ-032 Scenario: req0 and req1 together after reset, addr 32'h84 / 32'h88 -> requester 0 written first; requester 1 written 3 cycles later; acks in that order.
REQ-033 Scenario: both held continuously for 6 writes -> grants alternate 0,1,0,1,0,1; io_we spacing exactly 3 cycles.
REQ-034 Scenario: req1 with addr1=32'h40 -> ack1 pulses, io_we stays 0, drop_cnt 0->1; 300 such writes -> drop_cnt=8'hFF.
REQ-035 Scenario: resetn pulled low during WRITE -> io_we and ack drop immediately, all outputs 0; after release no residual write occurs.
REQ-036 Scenario: req0 raised during GAP of a requester-1 write -> requester 0 granted on the IDLE edge; no ack before its own WRITE cycle.
